// File: rtl/emu_time_pkg.sv
// Shared types and default widths for the emulator time manager.
package emu_time_pkg;

    localparam int unsigned DEF_DT_WIDTH   = 32;
    localparam int unsigned DEF_TIME_WIDTH = 64;

    typedef logic [DEF_DT_WIDTH-1:0]   dt_t;
    typedef logic [DEF_TIME_WIDTH-1:0] time_t;

    // Timestep issued when no requester is enabled.
    localparam dt_t DEF_DT_MAX = '1;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STOPPED = 1'b1
    } emu_state_t;

endpackage

// File: rtl/dt_min_tree.sv
// Masked unsigned minimum over N_REQ timestep requests.
// Recursive halving gives a balanced tree of log2(N_REQ) comparator levels;
// disabled slots contribute DT_MAX so they never win against a real request.
module dt_min_tree
    import emu_time_pkg::*;
#(
    parameter int unsigned         N_REQ    = 4,
    parameter int unsigned         DT_WIDTH = DEF_DT_WIDTH,
    parameter logic [DT_WIDTH-1:0] DT_MAX   = '1
) (
    input  logic [N_REQ*DT_WIDTH-1:0] req,
    input  logic [N_REQ-1:0]          req_en,
    output logic [DT_WIDTH-1:0]       dt_min
);

    generate
        if (N_REQ == 1) begin : g_leaf
            // Single slot: pass the request through or substitute DT_MAX.
            assign dt_min = req_en[0] ? req : DT_MAX;
        end else begin : g_node
            localparam int unsigned N_LO = N_REQ / 2;
            localparam int unsigned N_HI = N_REQ - N_LO;

            logic [DT_WIDTH-1:0] min_lo;
            logic [DT_WIDTH-1:0] min_hi;

            dt_min_tree #(
                .N_REQ    (N_LO),
                .DT_WIDTH (DT_WIDTH),
                .DT_MAX   (DT_MAX)
            ) u_lo (
                .req    (req[N_LO*DT_WIDTH-1:0]),
                .req_en (req_en[N_LO-1:0]),
                .dt_min (min_lo)
            );

            dt_min_tree #(
                .N_REQ    (N_HI),
                .DT_WIDTH (DT_WIDTH),
                .DT_MAX   (DT_MAX)
            ) u_hi (
                .req    (req[N_REQ*DT_WIDTH-1:N_LO*DT_WIDTH]),
                .req_en (req_en[N_REQ-1:N_LO]),
                .dt_min (min_hi)
            );

            // Combine the two halves.
            assign dt_min = (min_hi < min_lo) ? min_hi : min_lo;
        end
    endgenerate

endmodule

// File: rtl/emu_time_manager.sv
// Central timestep scheduler: broadcasts the minimum requested dt, keeps the
// absolute emulation time and halts exactly on a software-armed stop time.
module emu_time_manager
    import emu_time_pkg::*;
#(
    parameter int unsigned         N_REQ      = 4,
    parameter int unsigned         DT_WIDTH   = DEF_DT_WIDTH,
    parameter int unsigned         TIME_WIDTH = DEF_TIME_WIDTH,
    parameter logic [DT_WIDTH-1:0] DT_MAX     = '1,
    parameter bit                  AUTO_START = 1'b1
) (
    input  logic                      emu_clk,
    input  logic                      emu_rst,
    input  logic [N_REQ*DT_WIDTH-1:0] emu_dt_req,
    input  logic [N_REQ-1:0]          req_en,
    input  logic                      emu_stall,
    input  logic                      stop_load,
    input  logic [TIME_WIDTH-1:0]     stop_time,
    input  logic                      start,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic                      stopped,
    output logic                      stop_hit
);

    emu_state_t            state;
    emu_state_t            state_nxt;
    logic                  stop_armed;
    logic                  armed_nxt;
    logic [TIME_WIDTH-1:0] stop_time_r;
    logic [TIME_WIDTH-1:0] stop_time_nxt;
    logic                  hit_nxt;

    logic [DT_WIDTH-1:0]   dt_min;
    logic [TIME_WIDTH-1:0] remaining;
    logic [DT_WIDTH-1:0]   dt_cand;
    logic                  stop_reached;

    dt_min_tree #(
        .N_REQ    (N_REQ),
        .DT_WIDTH (DT_WIDTH),
        .DT_MAX   (DT_MAX)
    ) u_dt_min_tree (
        .req    (emu_dt_req),
        .req_en (req_en),
        .dt_min (dt_min)
    );

    // Timestep datapath: clip to the armed stop target, gate by state/stall/reset.
    always_comb begin
        remaining    = '0;
        dt_cand      = dt_min;
        emu_dt       = '0;
        stop_reached = 1'b0;

        if (stop_time_r > emu_time) begin
            remaining = stop_time_r - emu_time;
        end

        if (stop_armed && (remaining < TIME_WIDTH'(dt_min))) begin
            dt_cand = remaining[DT_WIDTH-1:0];
        end

        if (!emu_rst && (state == ST_RUN) && !emu_stall) begin
            emu_dt = dt_cand;
        end

        // Target is reached this step; a stale target (remaining=0) also lands here.
        stop_reached = stop_armed && !emu_stall && (remaining == TIME_WIDTH'(emu_dt));
    end

    // Next-state logic for run/stop control and the stop target.
    always_comb begin
        state_nxt     = state;
        armed_nxt     = stop_armed;
        stop_time_nxt = stop_time_r;
        hit_nxt       = 1'b0;

        case (state)
            ST_RUN: begin
                if (stop_reached && !stop_load) begin
                    state_nxt = ST_STOPPED;
                    armed_nxt = 1'b0;
                    hit_nxt   = 1'b1;
                end
            end
            ST_STOPPED: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_STOPPED;
            end
        endcase

        // A new target always wins over a trigger in the same cycle.
        if (stop_load) begin
            stop_time_nxt = stop_time;
            armed_nxt     = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            if (AUTO_START) begin
                state <= ST_RUN;
            end else begin
                state <= ST_STOPPED;
            end
        end else begin
            state <= state_nxt;
        end
    end

    // Absolute time, stop target and stop pulse registers.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            emu_time    <= '0;
            stop_armed  <= 1'b0;
            stop_time_r <= '0;
            stop_hit    <= 1'b0;
        end else begin
            emu_time    <= emu_time + TIME_WIDTH'(emu_dt);
            stop_armed  <= armed_nxt;
            stop_time_r <= stop_time_nxt;
            stop_hit    <= hit_nxt;
        end
    end

    assign stopped = (state == ST_STOPPED);

endmodule

// File: tb/tb_emu_time_manager.sv
// Directed self-checking bench for emu_time_manager (default parameters).
`timescale 1ns/1ps
module tb_emu_time_manager;

    logic         emu_clk;
    logic         emu_rst;
    logic [127:0] emu_dt_req;
    logic [3:0]   req_en;
    logic         emu_stall;
    logic         stop_load;
    logic [63:0]  stop_time;
    logic         start;
    logic [31:0]  emu_dt;
    logic [63:0]  emu_time;
    logic         stopped;
    logic         stop_hit;

    int total = 0;
    int bad   = 0;

    emu_time_manager dut (
        .emu_clk    (emu_clk),
        .emu_rst    (emu_rst),
        .emu_dt_req (emu_dt_req),
        .req_en     (req_en),
        .emu_stall  (emu_stall),
        .stop_load  (stop_load),
        .stop_time  (stop_time),
        .start      (start),
        .emu_dt     (emu_dt),
        .emu_time   (emu_time),
        .stopped    (stopped),
        .stop_hit   (stop_hit)
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    task automatic tick();
        @(posedge emu_clk);
        #2;
    endtask

    task automatic set_reqs(input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3);
        emu_dt_req = {r3, r2, r1, r0};
    endtask

    task automatic test_reset();
        @(posedge emu_clk);
        #2;
        total++; if (emu_time !== 64'd0) begin bad++; $display("FAIL reset_time: got %0d want 0", emu_time); end
        total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL reset_dt: got %0d want 0", emu_dt); end
        total++; if (stopped !== 1'b0) begin bad++; $display("FAIL reset_stopped: got %0b want 0", stopped); end
        total++; if (stop_hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %0b want 0", stop_hit); end
        set_reqs(32'd5, 32'd3, 32'd7, 32'd9);
        req_en = 4'b1111;
        #1;
        total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL reset_dt_gated: got %0d want 0", emu_dt); end
    endtask

    task automatic test_min();
        @(posedge emu_clk);
        #2;
        emu_rst = 1'b0;
        #1;
        total++; if (emu_dt !== 32'd3) begin bad++; $display("FAIL min_dt0: got %0d want 3", emu_dt); end
        total++; if (emu_time !== 64'd0) begin bad++; $display("FAIL min_time0: got %0d want 0", emu_time); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++; if (emu_time !== 64'(3 * k)) begin bad++; $display("FAIL min_time%0d: got %0d want %0d", k, emu_time, 3 * k); end
            total++; if (emu_dt !== 32'd3) begin bad++; $display("FAIL min_dt%0d: got %0d want 3", k, emu_dt); end
        end
    endtask

    task automatic test_mask();
        req_en = 4'b0000;
        #1;
        total++; if (emu_dt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mask_none: got %0h want ffffffff", emu_dt); end
        req_en = 4'b0100;
        #1;
        total++; if (emu_dt !== 32'd7) begin bad++; $display("FAIL mask_slot2: got %0d want 7", emu_dt); end
        set_reqs(32'd0, 32'd3, 32'd7, 32'd9);
        req_en = 4'b0011;
        #1;
        total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL mask_zero_req: got %0d want 0", emu_dt); end
        tick();
        total++; if (emu_time !== 64'd12) begin bad++; $display("FAIL mask_hold: got %0d want 12", emu_time); end
        set_reqs(32'd5, 32'd3, 32'd7, 32'd9);
        req_en = 4'b0100;
        tick();
        total++; if (emu_time !== 64'd19) begin bad++; $display("FAIL mask_adv: got %0d want 19", emu_time); end
    endtask

    task automatic test_stop();
        set_reqs(32'd4, 32'd4, 32'd4, 32'd4);
        req_en    = 4'b1111;
        stop_load = 1'b1;
        stop_time = 64'd29;
        #1;
        total++; if (emu_dt !== 32'd4) begin bad++; $display("FAIL stop_dt_a: got %0d want 4", emu_dt); end
        tick();
        stop_load = 1'b0;
        #1;
        total++; if (emu_time !== 64'd23) begin bad++; $display("FAIL stop_time_b: got %0d want 23", emu_time); end
        total++; if (emu_dt !== 32'd4) begin bad++; $display("FAIL stop_dt_b: got %0d want 4", emu_dt); end
        tick();
        total++; if (emu_time !== 64'd27) begin bad++; $display("FAIL stop_time_c: got %0d want 27", emu_time); end
        total++; if (emu_dt !== 32'd2) begin bad++; $display("FAIL stop_dt_clip: got %0d want 2", emu_dt); end
        total++; if (stop_hit !== 1'b0) begin bad++; $display("FAIL stop_hit_early: got %0b want 0", stop_hit); end
        tick();
        total++; if (emu_time !== 64'd29) begin bad++; $display("FAIL stop_time_exact: got %0d want 29", emu_time); end
        total++; if (stopped !== 1'b1) begin bad++; $display("FAIL stop_stopped: got %0b want 1", stopped); end
        total++; if (stop_hit !== 1'b1) begin bad++; $display("FAIL stop_hit: got %0b want 1", stop_hit); end
        total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL stop_dt_zero: got %0d want 0", emu_dt); end
        tick();
        total++; if (emu_time !== 64'd29) begin bad++; $display("FAIL stop_time_hold: got %0d want 29", emu_time); end
        total++; if (stop_hit !== 1'b0) begin bad++; $display("FAIL stop_hit_pulse: got %0b want 0", stop_hit); end
        total++; if (stopped !== 1'b1) begin bad++; $display("FAIL stop_stay: got %0b want 1", stopped); end
        start = 1'b1;
        #1;
        total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL stop_dt_start_cyc: got %0d want 0", emu_dt); end
        tick();
        start = 1'b0;
        #1;
        total++; if (stopped !== 1'b0) begin bad++; $display("FAIL stop_resume: got %0b want 0", stopped); end
        total++; if (emu_dt !== 32'd4) begin bad++; $display("FAIL stop_resume_dt: got %0d want 4", emu_dt); end
        tick();
        total++; if (emu_time !== 64'd33) begin bad++; $display("FAIL stop_resume_time: got %0d want 33", emu_time); end
    endtask

    task automatic test_past();
        stop_load = 1'b1;
        stop_time = 64'd15;
        #1;
        total++; if (emu_dt !== 32'd4) begin bad++; $display("FAIL past_load_dt: got %0d want 4", emu_dt); end
        tick();
        stop_load = 1'b0;
        #1;
        total++; if (emu_time !== 64'd37) begin bad++; $display("FAIL past_time: got %0d want 37", emu_time); end
        total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL past_dt: got %0d want 0", emu_dt); end
        total++; if (stopped !== 1'b0) begin bad++; $display("FAIL past_not_yet: got %0b want 0", stopped); end
        tick();
        total++; if (stopped !== 1'b1) begin bad++; $display("FAIL past_stopped: got %0b want 1", stopped); end
        total++; if (stop_hit !== 1'b1) begin bad++; $display("FAIL past_hit: got %0b want 1", stop_hit); end
        total++; if (emu_time !== 64'd37) begin bad++; $display("FAIL past_time_hold: got %0d want 37", emu_time); end
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        total++; if (stopped !== 1'b0) begin bad++; $display("FAIL past_resume: got %0b want 0", stopped); end
        total++; if (emu_dt !== 32'd4) begin bad++; $display("FAIL past_resume_dt: got %0d want 4", emu_dt); end
    endtask

    task automatic test_load_wins();
        stop_load = 1'b1;
        stop_time = 64'd45;
        tick();
        stop_time = 64'd100;
        start     = 1'b1;
        #1;
        total++; if (emu_time !== 64'd41) begin bad++; $display("FAIL lw_time: got %0d want 41", emu_time); end
        total++; if (emu_dt !== 32'd4) begin bad++; $display("FAIL lw_dt: got %0d want 4", emu_dt); end
        tick();
        stop_load = 1'b0;
        start     = 1'b0;
        #1;
        total++; if (emu_time !== 64'd45) begin bad++; $display("FAIL lw_time2: got %0d want 45", emu_time); end
        total++; if (stopped !== 1'b0) begin bad++; $display("FAIL lw_stopped: got %0b want 0", stopped); end
        total++; if (stop_hit !== 1'b0) begin bad++; $display("FAIL lw_hit: got %0b want 0", stop_hit); end
        total++; if (emu_dt !== 32'd4) begin bad++; $display("FAIL lw_dt2: got %0d want 4", emu_dt); end
        tick();
        total++; if (emu_time !== 64'd49) begin bad++; $display("FAIL lw_time3: got %0d want 49", emu_time); end
    endtask

    task automatic test_stall();
        emu_stall = 1'b1;
        stop_load = 1'b1;
        stop_time = 64'd49;
        #1;
        total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL stall_dt0: got %0d want 0", emu_dt); end
        tick();
        stop_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (emu_time !== 64'd49) begin bad++; $display("FAIL stall_time%0d: got %0d want 49", i, emu_time); end
            total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL stall_dt%0d: got %0d want 0", i, emu_dt); end
            total++; if (stopped !== 1'b0 || stop_hit !== 1'b0) begin bad++; $display("FAIL stall_nostop%0d: got %0b%0b want 00", i, stopped, stop_hit); end
            tick();
        end
        emu_stall = 1'b0;
        #1;
        total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL stall_release_dt: got %0d want 0", emu_dt); end
        tick();
        total++; if (stopped !== 1'b1 || stop_hit !== 1'b1) begin bad++; $display("FAIL stall_release_stop: got %0b%0b want 11", stopped, stop_hit); end
        total++; if (emu_time !== 64'd49) begin bad++; $display("FAIL stall_release_time: got %0d want 49", emu_time); end
        start     = 1'b1;
        stop_load = 1'b1;
        stop_time = 64'd57;
        tick();
        start     = 1'b0;
        stop_load = 1'b0;
        #1;
        total++; if (stopped !== 1'b0) begin bad++; $display("FAIL both_run: got %0b want 0", stopped); end
        total++; if (emu_dt !== 32'd4) begin bad++; $display("FAIL both_dt: got %0d want 4", emu_dt); end
        tick();
        total++; if (emu_time !== 64'd53) begin bad++; $display("FAIL both_time: got %0d want 53", emu_time); end
        tick();
        total++; if (emu_time !== 64'd57) begin bad++; $display("FAIL both_time2: got %0d want 57", emu_time); end
        total++; if (stopped !== 1'b1 || stop_hit !== 1'b1) begin bad++; $display("FAIL both_stop: got %0b%0b want 11", stopped, stop_hit); end
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        total++; if (stopped !== 1'b0) begin bad++; $display("FAIL both_resume: got %0b want 0", stopped); end
    endtask

    task automatic test_async_reset();
        stop_load = 1'b1;
        stop_time = 64'd8;
        tick();
        stop_load = 1'b0;
        #1;
        total++; if (emu_time !== 64'd61) begin bad++; $display("FAIL ar_pre_time: got %0d want 61", emu_time); end
        total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL ar_pre_dt: got %0d want 0", emu_dt); end
        #2;
        emu_rst = 1'b1;
        #1;
        total++; if (emu_time !== 64'd0) begin bad++; $display("FAIL ar_time: got %0d want 0", emu_time); end
        total++; if (emu_dt !== 32'd0) begin bad++; $display("FAIL ar_dt: got %0d want 0", emu_dt); end
        total++; if (stopped !== 1'b0) begin bad++; $display("FAIL ar_stopped: got %0b want 0", stopped); end
        @(posedge emu_clk);
        #2;
        emu_rst = 1'b0;
        #1;
        total++; if (emu_dt !== 32'd4) begin bad++; $display("FAIL ar_dt_resume: got %0d want 4", emu_dt); end
        tick();
        total++; if (emu_time !== 64'd4) begin bad++; $display("FAIL ar_time4: got %0d want 4", emu_time); end
        tick();
        total++; if (emu_time !== 64'd8) begin bad++; $display("FAIL ar_time8: got %0d want 8", emu_time); end
        tick();
        total++; if (emu_time !== 64'd12) begin bad++; $display("FAIL ar_time12: got %0d want 12", emu_time); end
        total++; if (stopped !== 1'b0 || stop_hit !== 1'b0) begin bad++; $display("FAIL ar_disarmed: got %0b%0b want 00", stopped, stop_hit); end
        total++; if (emu_dt !== 32'd4) begin bad++; $display("FAIL ar_dt_run: got %0d want 4", emu_dt); end
    endtask

    initial begin
        emu_rst    = 1'b1;
        emu_dt_req = '0;
        req_en     = 4'b0000;
        emu_stall  = 1'b0;
        stop_load  = 1'b0;
        stop_time  = '0;
        start      = 1'b0;

        test_reset();
        test_min();
        test_mask();
        test_stop();
        test_past();
        test_load_wins();
        test_stall();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
